// File: rtl/pipeline_decode_rf.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_decode_rf
// Brief    : RV32I ID stage - field decode, immediate generation, register
//            file with same-cycle WB bypass, ID/EX register with stall/flush.
//            Optional macro DECODE_ILLEGAL_EN adds the registered illegal_o.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_decode_rf #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    input  logic [31:0]       instruction_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              reg_write_i,
    input  logic [REG_AW-1:0] write_reg_i,
    input  logic [XLEN-1:0]   write_data_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   read_data1_o,
    output logic [XLEN-1:0]   read_data2_o,
    output logic [XLEN-1:0]   imm_o
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic              illegal_o
`endif
);

    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [REG_AW:0] NREGS_W = (REG_AW + 1)'(NUM_REGS);

    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;
    logic [REG_AW-1:0] rd_f;
    logic              wb_en;
    logic              wb_hit;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic [XLEN-1:0]   rd1_hold;
    logic [XLEN-1:0]   rd2_hold;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_d;

    assign rs1_f  = REG_AW'(instruction_i[19:15]);
    assign rs2_f  = REG_AW'(instruction_i[24:20]);
    assign rd_f   = REG_AW'(instruction_i[11:7]);
    assign wb_hit = reg_write_i && (write_reg_i != '0);
    assign wb_en  = wb_hit && ({1'b0, write_reg_i} < NREGS_W);

    function automatic logic [XLEN-1:0] rf_read(input logic [REG_AW-1:0] rs);
        logic [XLEN-1:0] val;
        val = '0;
        if (rs != '0) begin
            if (wb_hit && (write_reg_i == rs))
                val = write_data_i;
            else if ({1'b0, rs} < NREGS_W)
                val = regs[rs[IDX_W-1:0]];
        end
        return val;
    endfunction

    always_comb begin
        rd1_d = rf_read(rs1_f);
        rd2_d = rf_read(rs2_f);
    end

    // Held operands pick up WB writes so a stalled instruction never sees stale data.
    always_comb begin
        rd1_hold = read_data1_o;
        rd2_hold = read_data2_o;
        if (wb_hit && (write_reg_i == rs1_o))
            rd1_hold = write_data_i;
        if (wb_hit && (write_reg_i == rs2_o))
            rd2_hold = write_data_i;
    end

    always_comb begin
        imm32 = '0;
        case (instruction_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
            7'b0100011:
                imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            7'b1100011:
                imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instruction_i[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_d = XLEN'($signed(imm32));
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_d;
    logic opc_ok;

    always_comb begin
        opc_ok = 1'b0;
        case (instruction_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111:
                opc_ok = 1'b1;
            default:
                opc_ok = 1'b0;
        endcase
        illegal_d = instr_valid_i &&
                    (!opc_ok || (instruction_i[1:0] != 2'b11) ||
                     ({1'b0, instruction_i[19:15]} >= 6'(NUM_REGS)) ||
                     ({1'b0, instruction_i[24:20]} >= 6'(NUM_REGS)) ||
                     ({1'b0, instruction_i[11:7]}  >= 6'(NUM_REGS)));
    end
`endif

    // Entry 0 is never written, so it stays zero from reset onward.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[write_reg_i[IDX_W-1:0]] <= write_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o      <= 1'b0;
            pc_o         <= '0;
            opcode_o     <= '0;
            funct3_o     <= '0;
            funct7_o     <= '0;
            rs1_o        <= '0;
            rs2_o        <= '0;
            rd_o         <= '0;
            read_data1_o <= '0;
            read_data2_o <= '0;
            imm_o        <= '0;
`ifdef DECODE_ILLEGAL_EN
            illegal_o    <= 1'b0;
`endif
        end else if (flush_i || stall_i) begin
            if (flush_i)
                valid_o <= 1'b0;
            read_data1_o <= rd1_hold;
            read_data2_o <= rd2_hold;
        end else begin
            valid_o      <= instr_valid_i;
            pc_o         <= pc_i;
            opcode_o     <= instruction_i[6:0];
            funct3_o     <= instruction_i[14:12];
            funct7_o     <= instruction_i[31:25];
            rs1_o        <= rs1_f;
            rs2_o        <= rs2_f;
            rd_o         <= rd_f;
            read_data1_o <= rd1_d;
            read_data2_o <= rd2_d;
            imm_o        <= imm_d;
`ifdef DECODE_ILLEGAL_EN
            illegal_o    <= illegal_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_decode_rf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_decode_rf
// Brief    : Scoreboard bench for pipeline_decode_rf (decode, bypass, stall,
//            flush, async reset, optional illegal decode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_decode_rf;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef DECODE_ILLEGAL_EN
    localparam int NUM_REGS = 16;
`else
    localparam int NUM_REGS = 32;
`endif

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        ill_chk;
        logic        illegal;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic [31:0]       instruction;
    logic [XLEN-1:0]   pc;
    logic              stall;
    logic              flush;
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
    logic [XLEN-1:0]   write_data;
    logic              valid;
    logic [XLEN-1:0]   pc_q;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   imm;
`ifdef DECODE_ILLEGAL_EN
    logic              illegal;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pipeline_decode_rf #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_valid_i (instr_valid),
        .instruction_i (instruction),
        .pc_i          (pc),
        .stall_i       (stall),
        .flush_i       (flush),
        .reg_write_i   (reg_write),
        .write_reg_i   (write_reg),
        .write_data_i  (write_data),
        .valid_o       (valid),
        .pc_o          (pc_q),
        .opcode_o      (opcode),
        .funct3_o      (funct3),
        .funct7_o      (funct7),
        .rs1_o         (rs1),
        .rs2_o         (rs2),
        .rd_o          (rd),
        .read_data1_o  (read_data1),
        .read_data2_o  (read_data2),
        .imm_o         (imm)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegal_o     (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] p, input logic [31:0] ins,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] im, input logic ic, input logic il);
        exp_t e;
        e.valid = v; e.pc = p; e.instr = ins; e.rd1 = d1; e.rd2 = d2;
        e.imm = im; e.ill_chk = ic; e.illegal = il;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".valid"},  64'(valid), 64'(e.valid));
        check({tag, ".pc"},     64'(pc_q), 64'(e.pc));
        check({tag, ".opcode"}, 64'(opcode), 64'(e.instr[6:0]));
        check({tag, ".funct3"}, 64'(funct3), 64'(e.instr[14:12]));
        check({tag, ".funct7"}, 64'(funct7), 64'(e.instr[31:25]));
        check({tag, ".rs1"},    64'(rs1), 64'(e.instr[19:15]));
        check({tag, ".rs2"},    64'(rs2), 64'(e.instr[24:20]));
        check({tag, ".rd"},     64'(rd), 64'(e.instr[11:7]));
        check({tag, ".rdata1"}, 64'(read_data1), 64'(e.rd1));
        check({tag, ".rdata2"}, 64'(read_data2), 64'(e.rd2));
        check({tag, ".imm"},    64'(imm), 64'(e.imm));
`ifdef DECODE_ILLEGAL_EN
        if (e.ill_chk)
            check({tag, ".illegal"}, 64'(illegal), 64'(e.illegal));
`endif
    endtask

    task automatic check_zero(input string tag);
        compare(tag, mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0));
    endtask

    task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                        input logic [31:0] p, input logic stl, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input exp_t e);
        exp_t got;
        @(negedge clk);
        instr_valid = iv; instruction = ins; pc = p;
        stall = stl; flush = fl;
        reg_write = we; write_reg = REG_AW'(wa); write_data = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare(tag, got);
    endtask

    localparam logic [31:0] ADDI = 32'hFFF28313;  // addi x6,x5,-1
    localparam logic [31:0] ADD8 = 32'h00738433;  // add x8,x7,x7
    localparam logic [31:0] ADDA = 32'h00700533;  // add x10,x0,x7
    localparam logic [31:0] SW   = 32'hFE20AE23;  // sw x2,-4(x1)
    localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] LUI  = 32'h123450B7;  // lui x1,0x12345
    localparam logic [31:0] JAL  = 32'h0010006F;  // jal x0,+2048

    initial begin
        rst_n = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0;
        stall = 1'b0; flush = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        step("wb_x5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAA,
             mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        step("addi", 1'b1, ADDI, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h100, ADDI, 32'hAA, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("bypass", 1'b1, ADD8, 32'h104, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234,
             mk(1'b1, 32'h104, ADD8, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0));
        step("wb_x0", 1'b1, ADDA, 32'h108, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD,
             mk(1'b1, 32'h108, ADDA, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0));
        step("rd_x0", 1'b1, ADDA, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h10C, ADDA, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0));
        step("sw", 1'b1, SW, 32'h110, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h110, SW, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0));
        step("beq", 1'b1, BEQ, 32'h114, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h114, BEQ, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0));
        step("lui", 1'b1, LUI, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h118, LUI, 32'h0, 32'h0, 32'h1234_5000, 1'b0, 1'b0));
        step("jal", 1'b1, JAL, 32'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h11C, JAL, 32'h0, 32'h0, 32'h0000_0800, 1'b0, 1'b0));

        // Stall: outputs hold while instruction_i changes; WB to x5 refreshes operand 1.
        step("ld_stall", 1'b1, ADDI, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h200, ADDI, 32'hAA, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("stall1", 1'b1, ADD8, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h200, ADDI, 32'hAA, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("stall2", 1'b1, JAL, 32'h208, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55,
             mk(1'b1, 32'h200, ADDI, 32'h55, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("stall3", 1'b1, SW, 32'h20C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h200, ADDI, 32'h55, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("flush", 1'b1, LUI, 32'h210, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,
             mk(1'b0, 32'h200, ADDI, 32'h55, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        step("reload", 1'b1, ADD8, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h300, ADD8, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0));

        // Asynchronous reset between edges while stalled.
        stall = 1'b1;
        rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        step("post_rst", 1'b1, ADDI, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h400, ADDI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));

        step("ill_reg", 1'b1, 32'h00208A33, 32'h404, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h404, 32'h00208A33, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1));
        step("ill_opc", 1'b1, 32'h0000007F, 32'h408, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h408, 32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1));
        step("legal", 1'b1, 32'h00310093, 32'h40C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b1, 32'h40C, 32'h00310093, 32'h0, 32'h0, 32'h3, 1'b1, 1'b0));
        step("ill_inv", 1'b0, 32'h0000007F, 32'h410, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk(1'b0, 32'h410, 32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
